// File: rtl/irq_controller_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : irq_pkg                                                           |
// | Brief  : shared types and constants for the vectored interrupt controller. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package irq_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    typedef logic [2:0] cause_t;

    // Bit of the CSRRSI/CSRRCI zimm field that addresses the global enable.
    localparam int unsigned C_IE_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/irq_controller_if.sv
// +----------------------------------------------------------------------------+
// | Module : irq_controller_if                                                 |
// | Brief  : core-side bundle for the interrupt controller (master = core).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface irq_controller_if
    import irq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0] irq_in;
    logic               csr_set;
    logic               csr_clr;
    logic [4:0]         csr_imm;
    logic               uret;
    logic               commit;
    logic [WIDTH-1:0]   pc_next;
    logic               take;
    logic [WIDTH-1:0]   handler_pc;
    logic               ret;
    logic [WIDTH-1:0]   epc;
    logic               in_isr;
    cause_t             cause;

    modport master (
        output irq_in, csr_set, csr_clr, csr_imm, uret, commit, pc_next,
        input  take, handler_pc, ret, epc, in_isr, cause
    );

    modport slave (
        input  irq_in, csr_set, csr_clr, csr_imm, uret, commit, pc_next,
        output take, handler_pc, ret, epc, in_isr, cause
    );
endinterface

`default_nettype wire

// File: rtl/irq_pending.sv
// +----------------------------------------------------------------------------+
// | Module : irq_pending                                                       |
// | Brief  : per-source 2-flop sync, rising-edge detect and sticky pending.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_pending #(
    parameter int NUM_SRC = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_SRC-1:0] i_irq,
    input  wire logic [NUM_SRC-1:0] i_clr,
    output logic      [NUM_SRC-1:0] o_pending
);
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_rise;

    assign w_rise    = r_sync2 & ~r_prev;
    assign o_pending = r_pending;

    // A new edge arriving on the clearing cycle must not be lost, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_sync1   <= i_irq;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pending <= (r_pending & ~i_clr) | w_rise;
        end
    end
endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// +----------------------------------------------------------------------------+
// | Module : irq_controller                                                    |
// | Brief  : vectored fixed-priority trap entry/return sequencer. Define       |
// |          IRQ_NESTING_EN for a NUM_SRC-deep preemption stack.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_controller
    import irq_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter int                NUM_SRC  = 3,
    parameter logic [WIDTH-1:0]  VEC_BASE = 32'h0000_3000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    irq_controller_if.slave bus
);
`ifdef IRQ_NESTING_EN
    localparam int C_DEPTH = NUM_SRC;
`else
    localparam int C_DEPTH = 1;
`endif
    localparam int C_SPW   = $clog2(C_DEPTH + 1);
    localparam int C_STK_N = 1 << C_SPW;

    state_t             r_state;
    logic               r_ie;
    logic [C_SPW-1:0]   r_sp;
    logic [WIDTH-1:0]   r_epc;
    cause_t             r_cause;
    logic [WIDTH-1:0]   r_epc_stk   [C_STK_N];
    cause_t             r_cause_stk [C_STK_N];
    logic               r_ie_stk    [C_STK_N];

    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_clr;
    cause_t             w_win;
    logic               w_elig;
    logic               w_take;
    logic               w_ret;
    logic [C_SPW-1:0]   w_top;

    irq_pending #(.NUM_SRC(NUM_SRC)) u_pending (
        .clk       (clk),
        .rst       (rst),
        .i_irq     (bus.irq_in),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );

    always_comb begin
        w_win = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_pending[k]) w_win = cause_t'(k);
        end
    end

`ifdef IRQ_NESTING_EN
    assign w_elig = (r_state == IDLE) || (r_ie && (w_win > r_cause));
`else
    assign w_elig = (r_state == IDLE);
`endif

    assign w_take = bus.commit && r_ie && (|w_pending) && !bus.uret && w_elig;
    assign w_ret  = bus.uret && (r_state == SERVICE);
    assign w_top  = r_sp - C_SPW'(1);

    always_comb begin
        w_clr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_clr[k] = w_take && (w_win == cause_t'(k));
        end
    end

    assign bus.take       = w_take;
    assign bus.ret        = w_ret;
    assign bus.handler_pc = VEC_BASE + (WIDTH'(w_win) << 2);
    assign bus.epc        = r_epc;
    assign bus.cause      = r_cause;
    assign bus.in_isr     = (r_state == SERVICE);

    // Later assignments win: trap entry/return override a same-cycle CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ie    <= 1'b0;
            r_sp    <= '0;
            r_epc   <= '0;
            r_cause <= '0;
            for (int i = 0; i < C_STK_N; i++) begin
                r_epc_stk[i]   <= '0;
                r_cause_stk[i] <= '0;
                r_ie_stk[i]    <= 1'b0;
            end
        end else begin
            if (bus.csr_clr && bus.csr_imm[C_IE_BIT]) begin
                r_ie <= 1'b0;
            end else if (bus.csr_set && bus.csr_imm[C_IE_BIT]) begin
                r_ie <= 1'b1;
            end

            if (w_ret) begin
                r_ie <= r_ie_stk[w_top];
                r_sp <= w_top;
                if (r_sp == C_SPW'(1)) begin
                    r_state <= IDLE;
                end else begin
                    r_epc   <= r_epc_stk[w_top - C_SPW'(1)];
                    r_cause <= r_cause_stk[w_top - C_SPW'(1)];
                end
            end else if (w_take) begin
                r_epc_stk[r_sp]   <= bus.pc_next;
                r_cause_stk[r_sp] <= w_win;
                r_ie_stk[r_sp]    <= r_ie;
                r_epc             <= bus.pc_next;
                r_cause           <= w_win;
                r_ie              <= 1'b0;
                r_sp              <= r_sp + C_SPW'(1);
                r_state           <= SERVICE;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// +----------------------------------------------------------------------------+
// | Module : tb_irq_controller                                                 |
// | Brief  : directed self-checking bench for irq_controller.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_irq_controller;
    import irq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    irq_controller_if #(.WIDTH(32), .NUM_SRC(3)) bus ();

    irq_controller #(.WIDTH(32), .NUM_SRC(3), .VEC_BASE(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_in  = '0;
        bus.csr_set = 1'b0;
        bus.csr_clr = 1'b0;
        bus.csr_imm = '0;
        bus.uret    = 1'b0;
        bus.commit  = 1'b0;
        bus.pc_next = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ie();
        bus.csr_set = 1'b1;
        bus.csr_imm = 5'd1;
        tick();
        bus.csr_set = 1'b0;
        bus.csr_imm = 5'd0;
    endtask

    // Raise the given sources, wait out the 3-cycle sync/edge path, drop them.
    task automatic pulse(input logic [2:0] mask);
        bus.irq_in = mask;
        tick();
        tick();
        tick();
        bus.irq_in = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        check("rst_take",   32'(bus.take),   32'd0);
        check("rst_ret",    32'(bus.ret),    32'd0);
        check("rst_epc",    bus.epc,         32'd0);
        check("rst_cause",  32'(bus.cause),  32'd0);
        check("rst_in_isr", 32'(bus.in_isr), 32'd0);

        // IE clear: request latches but is never taken
        bus.commit = 1'b1;
        bus.irq_in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ie0_take", 32'(bus.take), 32'd0);
            tick();
        end
        bus.irq_in = '0;
        check("ie0_pend", 32'(dut.u_pending.o_pending), 32'd2);
        settle();
        check("ie0_take_late", 32'(bus.take), 32'd0);

        // Single source 0 taken
        do_reset();
        set_ie();
        check("ie_set", 32'(dut.r_ie), 32'd1);
        pulse(3'b001);
        bus.commit  = 1'b1;
        bus.pc_next = 32'h40;
        settle();
        check("t2_take", 32'(bus.take), 32'd1);
        check("t2_vec",  bus.handler_pc, 32'h3000);
        tick();
        check("t2_epc",    bus.epc,         32'h40);
        check("t2_in_isr", 32'(bus.in_isr), 32'd1);
        check("t2_ie",     32'(dut.r_ie),   32'd0);
        check("t2_cause",  32'(bus.cause),  32'd0);
        check("t2_no_b2b", 32'(bus.take),   32'd0);

        // Priority: sources 0 and 2 together
        do_reset();
        set_ie();
        pulse(3'b101);
        bus.commit  = 1'b1;
        bus.pc_next = 32'h100;
        settle();
        check("t3_take1", 32'(bus.take), 32'd1);
        check("t3_vec1",  bus.handler_pc, 32'h3008);
        tick();
        check("t3_cause1", 32'(bus.cause), 32'd2);
        bus.uret = 1'b1;
        settle();
        check("t3_ret",      32'(bus.ret),  32'd1);
        check("t3_ret_epc",  bus.epc,       32'h100);
        check("t3_ret_take", 32'(bus.take), 32'd0);
        tick();
        bus.uret    = 1'b0;
        bus.pc_next = 32'h200;
        check("t3_idle", 32'(bus.in_isr), 32'd0);
        settle();
        check("t3_take2", 32'(bus.take), 32'd1);
        check("t3_vec2",  bus.handler_pc, 32'h3000);
        tick();
        check("t3_cause2", 32'(bus.cause), 32'd0);
        check("t3_epc2",   bus.epc,        32'h200);

        // set/clr collision and uret in IDLE
        do_reset();
        set_ie();
        bus.csr_set = 1'b1;
        bus.csr_clr = 1'b1;
        bus.csr_imm = 5'd1;
        tick();
        bus.csr_set = 1'b0;
        bus.csr_clr = 1'b0;
        bus.csr_imm = 5'd0;
        check("t4_clr_wins", 32'(dut.r_ie), 32'd0);
        bus.uret = 1'b1;
        settle();
        check("t4_ret_idle", 32'(bus.ret), 32'd0);
        tick();
        bus.uret = 1'b0;
        check("t4_in_isr", 32'(bus.in_isr), 32'd0);
        check("t4_epc",    bus.epc,         32'd0);

        // Nested request from source 2 while servicing source 0
        do_reset();
        set_ie();
        pulse(3'b001);
        bus.commit  = 1'b1;
        bus.pc_next = 32'h40;
        tick();
        bus.commit  = 1'b0;
        set_ie();
        check("t5_reenable", 32'(dut.r_ie), 32'd1);
        pulse(3'b100);
        bus.commit  = 1'b1;
        bus.pc_next = 32'h80;
        settle();
`ifdef IRQ_NESTING_EN
        check("t5_nest_take", 32'(bus.take), 32'd1);
        check("t5_nest_vec",  bus.handler_pc, 32'h3008);
        tick();
        check("t5_nest_epc",   bus.epc,        32'h80);
        check("t5_nest_cause", 32'(bus.cause), 32'd2);
        bus.uret = 1'b1;
        settle();
        check("t5_ret1",     32'(bus.ret), 32'd1);
        check("t5_ret1_epc", bus.epc,      32'h80);
        tick();
        check("t5_inner_epc",  bus.epc,         32'h40);
        check("t5_inner_isr",  32'(bus.in_isr), 32'd1);
        settle();
        check("t5_ret2",     32'(bus.ret), 32'd1);
        check("t5_ret2_epc", bus.epc,      32'h40);
        tick();
        bus.uret = 1'b0;
        check("t5_out_isr", 32'(bus.in_isr), 32'd0);
`else
        check("t5_no_nest", 32'(bus.take), 32'd0);
        tick();
        bus.uret = 1'b1;
        settle();
        check("t5_ret",     32'(bus.ret), 32'd1);
        check("t5_ret_epc", bus.epc,      32'h40);
        tick();
        bus.uret = 1'b0;
        check("t5_out_isr", 32'(bus.in_isr), 32'd0);
        settle();
        check("t5_late_take", 32'(bus.take),  32'd1);
        check("t5_late_vec",  bus.handler_pc, 32'h3008);
        tick();
`endif
        bus.commit = 1'b0;

        // Reset in the middle of a handler with requests pending
        do_reset();
        set_ie();
        pulse(3'b001);
        bus.commit  = 1'b1;
        bus.pc_next = 32'h44;
        tick();
        bus.commit  = 1'b0;
        pulse(3'b110);
        check("t6_pend_pre", 32'(dut.u_pending.o_pending), 32'd6);
        rst = 1'b1;
        tick();
        check("t6_take",   32'(bus.take),   32'd0);
        check("t6_ret",    32'(bus.ret),    32'd0);
        check("t6_epc",    bus.epc,         32'd0);
        check("t6_cause",  32'(bus.cause),  32'd0);
        check("t6_in_isr", 32'(bus.in_isr), 32'd0);
        check("t6_ie",     32'(dut.r_ie),   32'd0);
        rst = 1'b0;
        set_ie();
        bus.commit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t6_no_take", 32'(bus.take), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
